gpu_rect_fill: RTL and testbench

Drawing engine directly downstream of the GPU register file. It consumes the decoded register outputs: cursor X, cursor Y, colour index, and a command word. On each software-issued go command it fills a clipped rectangle of framebuffer pixels with the colour index. Pixels are issued one per cycle as framebuffer write requests over a valid/ready handshake to the framebuffer write port.

---
 rtl/gpu_pkg.sv | 23 ++
 rtl/gpu_rect_clip.sv | 43 ++++
 rtl/gpu_rect_fill.sv | 193 +++++++++++++++++++
 tb/tb_gpu_rect_fill.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared constants, command-word field positions and FSM state type for the
// rectangle fill engine.
package gpu_pkg;

   localparam int unsigned FB_WIDTH_DEF  = 320;
   localparam int unsigned FB_HEIGHT_DEF = 240;

   // Command word layout: [31] go toggle, [24:16] height, [8:0] width
   localparam int unsigned CMD_GO_BIT = 31;
   localparam int unsigned CMD_W_LSB  = 0;
   localparam int unsigned CMD_W_MSB  = 8;
   localparam int unsigned CMD_H_LSB  = 16;
   localparam int unsigned CMD_H_MSB  = 24;
   localparam int unsigned DIM_BITS   = CMD_W_MSB - CMD_W_LSB + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      DRAW  = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/gpu_rect_clip.sv
// Combinational rectangle clipper: trims a WxH rectangle at (x0,y0) to the
// framebuffer and returns the address of its top-left pixel.
//   x0_i, y0_i  : origin, full register width (no truncation before compare)
//   w_i, h_i    : requested size
//   empty_c     : nothing to draw
//   ew_c, eh_c  : clipped width/height (valid when !empty_c)
//   row_base_c  : y0*FB_WIDTH + x0 (valid when !empty_c)
module gpu_rect_clip
   import gpu_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned FB_WIDTH  = FB_WIDTH_DEF,
   parameter int unsigned FB_HEIGHT = FB_HEIGHT_DEF,
   localparam int unsigned FB_ADDR_BITS = $clog2(FB_WIDTH * FB_HEIGHT)
) (
   input  logic [WIDTH-1:0]        x0_i,
   input  logic [WIDTH-1:0]        y0_i,
   input  logic [DIM_BITS-1:0]     w_i,
   input  logic [DIM_BITS-1:0]     h_i,
   output logic                    empty_c,
   output logic [DIM_BITS-1:0]     ew_c,
   output logic [DIM_BITS-1:0]     eh_c,
   output logic [FB_ADDR_BITS-1:0] row_base_c
);

   logic [WIDTH-1:0] x_room;
   logic [WIDTH-1:0] y_room;

   // Room left to the right/bottom edge; wraps when out of range, but then
   // empty_c is set and ew_c/eh_c are don't-care.
   always_comb begin
      x_room     = WIDTH'(FB_WIDTH) - x0_i;
      y_room     = WIDTH'(FB_HEIGHT) - y0_i;
      empty_c    = (x0_i >= WIDTH'(FB_WIDTH)) || (y0_i >= WIDTH'(FB_HEIGHT)) ||
                   (w_i == '0) || (h_i == '0);
      // min(w, room) never exceeds w, so the result always fits DIM_BITS
      ew_c       = (WIDTH'(w_i) < x_room) ? w_i : DIM_BITS'(x_room);
      eh_c       = (WIDTH'(h_i) < y_room) ? h_i : DIM_BITS'(y_room);
      // Constant multiplier: reduces to shift/add in synthesis
      row_base_c = FB_ADDR_BITS'(y0_i) * FB_ADDR_BITS'(FB_WIDTH) + FB_ADDR_BITS'(x0_i);
   end

endmodule

// File: rtl/gpu_rect_fill.sv
// Rectangle fill engine. A change of the go bit in the command word starts a
// clipped fill of the rectangle (cursor X/Y, cmd width/height) with the colour
// index, emitting one framebuffer write per accepted valid/ready handshake.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   gpu_cp_x_i/_y_i     : rectangle origin
//   gpu_index_i         : colour, low PIXEL_BITS used
//   gpu_cmd_i           : [31] go toggle, [24:16] height, [8:0] width
//   fb_addr_o/data_o    : write request payload, held while stalled
//   fb_valid_o/ready_i  : write request handshake
//   busy_o, done_o      : engine active / one-cycle completion pulse
//   pix_count_o         : running count of accepted writes
module gpu_rect_fill
   import gpu_pkg::*;
#(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned FB_WIDTH   = FB_WIDTH_DEF,
   parameter int unsigned FB_HEIGHT  = FB_HEIGHT_DEF,
   parameter int unsigned PIXEL_BITS = 8,
   localparam int unsigned FB_ADDR_BITS = $clog2(FB_WIDTH * FB_HEIGHT)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [WIDTH-1:0]        gpu_cp_x_i,
   input  logic [WIDTH-1:0]        gpu_cp_y_i,
   input  logic [WIDTH-1:0]        gpu_index_i,
   input  logic [WIDTH-1:0]        gpu_cmd_i,
   output logic [FB_ADDR_BITS-1:0] fb_addr_o,
   output logic [PIXEL_BITS-1:0]   fb_data_o,
   output logic                    fb_valid_o,
   input  logic                    fb_ready_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic [WIDTH-1:0]        pix_count_o
);

   state_e                  state_q, state_d;
   logic                    last_go_q, last_go_d;
   logic [WIDTH-1:0]        x0_q, x0_d, y0_q, y0_d;
   logic [DIM_BITS-1:0]     w_q, w_d, h_q, h_d;
   logic [DIM_BITS-1:0]     ew_q, ew_d, eh_q, eh_d;
   logic [DIM_BITS-1:0]     col_q, col_d, row_q, row_d;
   logic [PIXEL_BITS-1:0]   colour_q, colour_d;
   logic [FB_ADDR_BITS-1:0] row_base_q, row_base_d, addr_q, addr_d;
   logic [WIDTH-1:0]        pix_q, pix_d;
   logic                    valid_q, valid_d, busy_q, busy_d, done_q, done_d;

   logic                    clip_empty;
   logic [DIM_BITS-1:0]     clip_ew, clip_eh;
   logic [FB_ADDR_BITS-1:0] clip_row_base;

   // Only a subset of the register bits is meaningful here
   logic unused_bits;
   assign unused_bits = ^{gpu_index_i, gpu_cmd_i};

   gpu_rect_clip #(
      .WIDTH    (WIDTH),
      .FB_WIDTH (FB_WIDTH),
      .FB_HEIGHT(FB_HEIGHT)
   ) u_clip (
      .x0_i      (x0_q),
      .y0_i      (y0_q),
      .w_i       (w_q),
      .h_i       (h_q),
      .empty_c   (clip_empty),
      .ew_c      (clip_ew),
      .eh_c      (clip_eh),
      .row_base_c(clip_row_base)
   );

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      last_go_d  = last_go_q;
      x0_d       = x0_q;
      y0_d       = y0_q;
      w_d        = w_q;
      h_d        = h_q;
      ew_d       = ew_q;
      eh_d       = eh_q;
      col_d      = col_q;
      row_d      = row_q;
      colour_d   = colour_q;
      row_base_d = row_base_q;
      addr_d     = addr_q;
      pix_d      = pix_q;

      unique case (state_q)
         IDLE: begin
            // A toggle seen while busy is still pending here if the bit differs
            if (gpu_cmd_i[CMD_GO_BIT] != last_go_q) begin
               last_go_d = gpu_cmd_i[CMD_GO_BIT];
               x0_d      = gpu_cp_x_i;
               y0_d      = gpu_cp_y_i;
               w_d       = gpu_cmd_i[CMD_W_MSB:CMD_W_LSB];
               h_d       = gpu_cmd_i[CMD_H_MSB:CMD_H_LSB];
               colour_d  = gpu_index_i[PIXEL_BITS-1:0];
               state_d   = SETUP;
            end
         end
         SETUP: begin
            if (clip_empty) begin
               state_d = DONE;
            end else begin
               state_d    = DRAW;
               ew_d       = clip_ew;
               eh_d       = clip_eh;
               row_base_d = clip_row_base;
               addr_d     = clip_row_base;
               col_d      = '0;
               row_d      = '0;
            end
         end
         DRAW: begin
            // valid is always high in DRAW, so ready alone marks acceptance
            if (fb_ready_i) begin
               pix_d = pix_q + WIDTH'(1);
               if (col_q == ew_q - DIM_BITS'(1)) begin
                  if (row_q == eh_q - DIM_BITS'(1)) begin
                     state_d = DONE;
                  end else begin
                     col_d      = '0;
                     row_d      = row_q + DIM_BITS'(1);
                     row_base_d = row_base_q + FB_ADDR_BITS'(FB_WIDTH);
                     addr_d     = row_base_q + FB_ADDR_BITS'(FB_WIDTH);
                  end
               end else begin
                  col_d  = col_q + DIM_BITS'(1);
                  addr_d = addr_q + FB_ADDR_BITS'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      valid_d = (state_d == DRAW);
      busy_d  = (state_d != IDLE);
      done_d  = (state_d == DONE);
   end

   // State and output registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         last_go_q  <= 1'b0;
         x0_q       <= '0;
         y0_q       <= '0;
         w_q        <= '0;
         h_q        <= '0;
         ew_q       <= '0;
         eh_q       <= '0;
         col_q      <= '0;
         row_q      <= '0;
         colour_q   <= '0;
         row_base_q <= '0;
         addr_q     <= '0;
         pix_q      <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_go_q  <= last_go_d;
         x0_q       <= x0_d;
         y0_q       <= y0_d;
         w_q        <= w_d;
         h_q        <= h_d;
         ew_q       <= ew_d;
         eh_q       <= eh_d;
         col_q      <= col_d;
         row_q      <= row_d;
         colour_q   <= colour_d;
         row_base_q <= row_base_d;
         addr_q     <= addr_d;
         pix_q      <= pix_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign fb_addr_o   = addr_q;
   assign fb_data_o   = colour_q;
   assign fb_valid_o  = valid_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign pix_count_o = pix_q;

endmodule

// File: tb/tb_gpu_rect_fill.sv
// Bench for gpu_rect_fill: table of directed commands, hand-written toggle and
// reset sequences, and randomized commands against a pixel-enumeration model.
module tb_gpu_rect_fill;

   localparam int FBW = 320;
   localparam int FBH = 240;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] cp_x = '0, cp_y = '0, index = '0, cmd = '0;
   logic [16:0] fb_addr;
   logic [7:0]  fb_data;
   logic        fb_valid, fb_ready = 1'b0, busy, done;
   logic [31:0] pix_count;

   always #5 clk = ~clk;

   gpu_rect_fill dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .gpu_cp_x_i (cp_x),
      .gpu_cp_y_i (cp_y),
      .gpu_index_i(index),
      .gpu_cmd_i  (cmd),
      .fb_addr_o  (fb_addr),
      .fb_data_o  (fb_data),
      .fb_valid_o (fb_valid),
      .fb_ready_i (fb_ready),
      .busy_o     (busy),
      .done_o     (done),
      .pix_count_o(pix_count)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic        go_bit = 1'b0;
   logic [7:0]  exp_col;
   longint      exp_pix = 0;
   int          got_addr[$];
   int          exp_addr[$];
   int          done_at;

   typedef struct {
      logic [31:0] x, y;
      int          w, h;
      logic [7:0]  idx;
      int          mode;   // 0 ready high, 1 ready alternating, 2 random
      int          n;      // expected write count
      int          first, last;
      int          done;   // expected done offset, 0 = not checked
   } vec_t;

   vec_t tbl[11];

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive_cmd(input logic [31:0] x, input logic [31:0] y,
                            input int w, input int h, input logic [7:0] idx);
      logic [8:0] w9, h9;
      w9    = 9'(w);
      h9    = 9'(h);
      cp_x  = x;
      cp_y  = y;
      index = {24'hABCDEF, idx};
      cmd   = {go_bit, 6'd0, h9, 7'd0, w9};
   endtask

   // Reference: enumerate the requested rectangle row-major, keep on-screen pixels
   task automatic model(input logic [31:0] x, input logic [31:0] y, input int w, input int h);
      longint px, py;
      exp_addr.delete();
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++) begin
            px = longint'(x) + c;
            py = longint'(y) + r;
            if (px < FBW && py < FBH) exp_addr.push_back(int'(py * FBW + px));
         end
   endtask

   // Observe the DUT cycle by cycle until done_o; optional go toggles mid-run
   task automatic collect(input int mode, input int tog_k, input int tog_n, input bit from_issue);
      bit         stall;
      logic [16:0] s_addr;
      logic [7:0]  s_data;
      stall = 0;
      s_addr = '0;
      s_data = '0;
      got_addr.delete();
      done_at = -1;
      for (int k = 1; k <= 4000; k++) begin
         @(negedge clk);
         if (tog_n > 0 && k >= tog_k && k < tog_k + tog_n) begin
            go_bit = ~go_bit;
            drive_cmd(32'd20, 32'd20, 2, 1, 8'h77);
         end
         fb_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'((k % 2) == 1) : 1'($urandom_range(0, 1));
         if (from_issue && k == 1) check("busy_in_setup", busy, 1);
         if (stall) begin
            check("stall_valid", fb_valid, 1);
            check("stall_addr", fb_addr, s_addr);
            check("stall_data", fb_data, s_data);
         end
         stall = 0;
         if (fb_valid) begin
            check("pix_data", fb_data, exp_col);
            if (fb_ready) got_addr.push_back(int'(fb_addr));
            else begin
               stall  = 1;
               s_addr = fb_addr;
               s_data = fb_data;
            end
         end
         if (done) begin
            check("busy_in_done", busy, 1);
            done_at = k;
            break;
         end
      end
      if (done_at < 0) check("done_timeout", 0, 1);
   endtask

   task automatic compare_writes(input string tag);
      check({tag, "_nwrites"}, got_addr.size(), exp_addr.size());
      for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
         check({tag, "_addr"}, got_addr[i], exp_addr[i]);
      exp_pix += exp_addr.size();
      check({tag, "_pixcount"}, pix_count, exp_pix & 64'hFFFF_FFFF);
   endtask

   task automatic run_cmd(input logic [31:0] x, input logic [31:0] y, input int w, input int h,
                          input logic [7:0] idx, input int mode, input string tag);
      exp_col = idx;
      @(negedge clk);
      go_bit = ~go_bit;
      drive_cmd(x, y, w, h, idx);
      fb_ready = 1'b1;
      collect(mode, 0, 0, 1'b1);
      model(x, y, w, h);
      compare_writes(tag);
      @(negedge clk);
      check({tag, "_done_pulse_end"}, done, 0);
      check({tag, "_busy_end"}, busy, 0);
   endtask

   initial begin
      tbl[0]  = '{32'd10, 32'd5, 1, 1, 8'h2A, 0, 1, 1610, 1610, 3};
      tbl[1]  = '{32'd10, 32'd5, 3, 2, 8'h11, 0, 6, 1610, 1932, 8};
      tbl[2]  = '{32'd10, 32'd5, 3, 2, 8'h33, 1, 6, 1610, 1932, 0};
      tbl[3]  = '{32'd318, 32'd239, 5, 5, 8'h44, 0, 2, 76798, 76799, 4};
      tbl[4]  = '{32'd400, 32'd0, 3, 3, 8'h55, 0, 0, -1, -1, 2};
      tbl[5]  = '{32'd0, 32'd0, 0, 4, 8'h56, 0, 0, -1, -1, 2};
      tbl[6]  = '{32'd0, 32'd240, 4, 4, 8'h57, 0, 0, -1, -1, 2};
      tbl[7]  = '{32'd0, 32'd0, 1, 1, 8'h58, 0, 1, 0, 0, 3};
      tbl[8]  = '{32'd319, 32'd0, 2, 3, 8'h59, 0, 3, 319, 959, 5};
      tbl[9]  = '{32'h0001_0005, 32'd0, 2, 2, 8'h5A, 0, 0, -1, -1, 2};
      tbl[10] = '{32'd0, 32'd0, 511, 1, 8'h5B, 0, 320, 0, 319, 322};

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_valid", fb_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_addr", fb_addr, 0);
      check("rst_data", fb_data, 0);
      check("rst_pix", pix_count, 0);

      // Directed table
      for (int i = 0; i < 11; i++) begin
         run_cmd(tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h, tbl[i].idx, tbl[i].mode,
                 $sformatf("vec%0d", i));
         check($sformatf("vec%0d_n", i), got_addr.size(), tbl[i].n);
         if (tbl[i].n > 0 && got_addr.size() > 0) begin
            check($sformatf("vec%0d_first", i), got_addr[0], tbl[i].first);
            check($sformatf("vec%0d_last", i), got_addr[got_addr.size()-1], tbl[i].last);
         end
         if (tbl[i].done > 0) check($sformatf("vec%0d_done_lat", i), done_at, tbl[i].done);
      end

      // Single toggle during a 4x4 draw starts a second command afterwards
      exp_col = 8'h21;
      @(negedge clk);
      go_bit = ~go_bit;
      drive_cmd(32'd0, 32'd0, 4, 4, 8'h21);
      fb_ready = 1'b1;
      collect(0, 4, 1, 1'b1);
      model(32'd0, 32'd0, 4, 4);
      compare_writes("tog1_first");
      exp_col = 8'h77;
      collect(0, 0, 0, 1'b0);
      model(32'd20, 32'd20, 2, 1);
      compare_writes("tog1_second");
      check("tog1_second_done_lat", done_at, 5);
      @(negedge clk);
      check("tog1_busy_end", busy, 0);

      // Two toggles during a draw cancel out
      exp_col = 8'h22;
      @(negedge clk);
      go_bit = ~go_bit;
      drive_cmd(32'd40, 32'd10, 4, 4, 8'h22);
      collect(0, 4, 2, 1'b1);
      model(32'd40, 32'd10, 4, 4);
      compare_writes("tog2");
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("tog2_no_cmd_busy", busy, 0);
         check("tog2_no_cmd_valid", fb_valid, 0);
      end

      // Random commands with random backpressure
      for (int i = 0; i < 30; i++) begin
         logic [31:0] rx, ry;
         rx = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 330));
         ry = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 250));
         run_cmd(rx, ry, $urandom_range(0, 12), $urandom_range(0, 8),
                 8'($urandom), 2, $sformatf("rnd%0d", i));
      end

      // Reset in the middle of a 4x4 draw
      begin
         int acc;
         bit reached;
         acc = 0;
         reached = 0;
         exp_col = 8'h66;
         @(negedge clk);
         go_bit = ~go_bit;
         drive_cmd(32'd0, 32'd0, 4, 4, 8'h66);
         fb_ready = 1'b1;
         for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (fb_valid && fb_ready) acc++;
            if (acc == 3) begin
               reached = 1;
               break;
            end
         end
         check("rstmid_reached_3", reached, 1);
         @(negedge clk);
         check("rstmid_pix_before", pix_count, (exp_pix + 3) & 64'hFFFF_FFFF);
         rst = 1'b1;
         @(negedge clk);
         check("rstmid_valid", fb_valid, 0);
         check("rstmid_busy", busy, 0);
         check("rstmid_pix", pix_count, 0);
         exp_pix = 0;
         go_bit = 1'b0;
         drive_cmd(32'd0, 32'd0, 4, 4, 8'h66);
         rst = 1'b0;
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rstmid_no_cmd_busy", busy, 0);
            check("rstmid_no_cmd_valid", fb_valid, 0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
